// File: rtl/decode_stage_pipelined_if.sv
// Decode-stage bus bundle: instruction/PC input, D/E control, the two
// register-file write ports (pipeline writeback and NI) and the registered
// D/E outputs.
//   slave  : the decode stage (receives *_i, drives *_o)
//   master : the environment (drives *_i, receives *_o)
// AW = $clog2(REG_N) is the register index width.
interface decode_stage_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
);
  localparam int AW = $clog2(REG_N);

  logic [31:0]       instr_i;
  logic [DATA_W-1:0] pc_i;
  logic              valid_i;
  logic              stall_i;
  logic              flush_i;
  logic [1:0]        ext_mode_i;
  logic              wb_we_i;
  logic [AW-1:0]     wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              ni_we_i;
  logic [AW-1:0]     ni_addr_i;
  logic [DATA_W-1:0] ni_data_i;

  logic              valid_o;
  logic [DATA_W-1:0] rd1_o;
  logic [DATA_W-1:0] rd2_o;
  logic [DATA_W-1:0] pc_o;
  logic [AW-1:0]     rs_o;
  logic [AW-1:0]     rt_o;
  logic [AW-1:0]     radd_o;
  logic [DATA_W-1:0] ext_o;

  modport slave (
    input  instr_i, pc_i, valid_i, stall_i, flush_i, ext_mode_i,
           wb_we_i, wb_addr_i, wb_data_i, ni_we_i, ni_addr_i, ni_data_i,
    output valid_o, rd1_o, rd2_o, pc_o, rs_o, rt_o, radd_o, ext_o
  );

  modport master (
    output instr_i, pc_i, valid_i, stall_i, flush_i, ext_mode_i,
           wb_we_i, wb_addr_i, wb_data_i, ni_we_i, ni_addr_i, ni_data_i,
    input  valid_o, rd1_o, rd2_o, pc_o, rs_o, rt_o, radd_o, ext_o
  );
endinterface

// File: rtl/decode_stage_pipelined.sv
// Decode stage for the NoC processing-element pipeline.
// Decodes a 32-bit instruction, reads two operands from a REG_N x DATA_W
// register file (written by pipeline writeback and by the network interface),
// extends the immediate and registers everything into the D/E register.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : decode_stage_pipelined_if.slave (instruction, control, write
//          ports in; D/E register fields out)
// Parameters: DATA_W datapath width, REG_N register count, FORWARD enables
// same-cycle write-through on operand reads.
module decode_stage_pipelined #(
  parameter int DATA_W  = 32,
  parameter int REG_N   = 32,
  parameter int FORWARD = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  decode_stage_pipelined_if.slave  bus
);
  localparam int AW = $clog2(REG_N);

  logic [DATA_W-1:0] rf [REG_N];

  logic [AW+4:0]     rs_ext, rt_ext, rd_ext;
  logic [AW-1:0]     rs_idx, rt_idx, rd_idx;
  logic [15:0]       imm16;
  logic [25:0]       imm26;
  logic [DATA_W-1:0] rd1_next, rd2_next, ext_next;
  logic [DATA_W-1:0] rd1_hold, rd2_hold;
  logic              unused_bits;

  // Widen each 5-bit field by AW zeros, then keep the low AW bits: this
  // truncates when AW<5 and zero-extends when AW>5 with one expression.
  assign rs_ext = {{AW{1'b0}}, bus.instr_i[25:21]};
  assign rt_ext = {{AW{1'b0}}, bus.instr_i[20:16]};
  assign rd_ext = {{AW{1'b0}}, bus.instr_i[15:11]};
  assign rs_idx = rs_ext[AW-1:0];
  assign rt_idx = rt_ext[AW-1:0];
  assign rd_idx = rd_ext[AW-1:0];
  assign imm16  = bus.instr_i[15:0];
  assign imm26  = bus.instr_i[25:0];

  assign unused_bits = ^{bus.instr_i[31:26], rs_ext[AW+4:AW],
                         rt_ext[AW+4:AW], rd_ext[AW+4:AW]};

  // Register file. r0 is never written; wb beats NI on an address clash.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      for (int i = 1; i < REG_N; i++) begin
        if (bus.wb_we_i && bus.wb_addr_i == AW'(i))
          rf[i] <= bus.wb_data_i;
        else if (bus.ni_we_i && bus.ni_addr_i == AW'(i))
          rf[i] <= bus.ni_data_i;
      end
    end
  end

  // Operand reads; later assignments take priority (r0 last of all).
  always_comb begin
    rd1_next = rf[rs_idx];
    if (FORWARD != 0 && bus.ni_we_i && bus.ni_addr_i == rs_idx) rd1_next = bus.ni_data_i;
    if (FORWARD != 0 && bus.wb_we_i && bus.wb_addr_i == rs_idx) rd1_next = bus.wb_data_i;
    if (rs_idx == '0) rd1_next = '0;
  end

  always_comb begin
    rd2_next = rf[rt_idx];
    if (FORWARD != 0 && bus.ni_we_i && bus.ni_addr_i == rt_idx) rd2_next = bus.ni_data_i;
    if (FORWARD != 0 && bus.wb_we_i && bus.wb_addr_i == rt_idx) rd2_next = bus.wb_data_i;
    if (rt_idx == '0) rd2_next = '0;
  end

  // While stalled, a held live instruction picks up writes to its sources
  // so the operands it eventually issues with are not stale.
  always_comb begin
    rd1_hold = bus.rd1_o;
    if (bus.valid_o && bus.rs_o != '0) begin
      if (bus.ni_we_i && bus.ni_addr_i == bus.rs_o) rd1_hold = bus.ni_data_i;
      if (bus.wb_we_i && bus.wb_addr_i == bus.rs_o) rd1_hold = bus.wb_data_i;
    end
  end

  always_comb begin
    rd2_hold = bus.rd2_o;
    if (bus.valid_o && bus.rt_o != '0) begin
      if (bus.ni_we_i && bus.ni_addr_i == bus.rt_o) rd2_hold = bus.ni_data_i;
      if (bus.wb_we_i && bus.wb_addr_i == bus.rt_o) rd2_hold = bus.wb_data_i;
    end
  end

  always_comb begin
    ext_next = '0;
    case (bus.ext_mode_i)
      2'b00:   ext_next = DATA_W'(imm16);
      2'b01:   ext_next = DATA_W'($signed(imm16));
      2'b10:   ext_next = DATA_W'({imm16, 16'h0000});
      default: ext_next = DATA_W'($signed(imm26));
    endcase
  end

  // D/E register: flush > stall > capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.valid_o <= 1'b0;
      bus.rd1_o   <= '0;
      bus.rd2_o   <= '0;
      bus.pc_o    <= '0;
      bus.rs_o    <= '0;
      bus.rt_o    <= '0;
      bus.radd_o  <= '0;
      bus.ext_o   <= '0;
    end else if (bus.flush_i) begin
      bus.valid_o <= 1'b0;
      bus.rd1_o   <= '0;
      bus.rd2_o   <= '0;
      bus.pc_o    <= '0;
      bus.rs_o    <= '0;
      bus.rt_o    <= '0;
      bus.radd_o  <= '0;
      bus.ext_o   <= '0;
    end else if (bus.stall_i) begin
      bus.rd1_o   <= rd1_hold;
      bus.rd2_o   <= rd2_hold;
    end else begin
      bus.valid_o <= bus.valid_i;
      bus.rd1_o   <= rd1_next;
      bus.rd2_o   <= rd2_next;
      bus.pc_o    <= bus.pc_i;
      bus.rs_o    <= rs_idx;
      bus.rt_o    <= rt_idx;
      bus.radd_o  <= rd_idx;
      bus.ext_o   <= ext_next;
    end
  end
endmodule

// File: tb/tb_decode_stage_pipelined.sv
`timescale 1ns/1ps
module tb_decode_stage_pipelined;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_pipelined_if #(.DATA_W(32), .REG_N(32)) ifa();
  decode_stage_pipelined_if #(.DATA_W(32), .REG_N(32)) ifb();
  decode_stage_pipelined_if #(.DATA_W(64), .REG_N(16)) ifc();

  decode_stage_pipelined #(.DATA_W(32), .REG_N(32), .FORWARD(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  decode_stage_pipelined #(.DATA_W(32), .REG_N(32), .FORWARD(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  decode_stage_pipelined #(.DATA_W(64), .REG_N(16), .FORWARD(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  // The FORWARD=0 instance sees exactly the same stimulus as the FORWARD=1 one.
  assign ifb.instr_i    = ifa.instr_i;
  assign ifb.pc_i       = ifa.pc_i;
  assign ifb.valid_i    = ifa.valid_i;
  assign ifb.stall_i    = ifa.stall_i;
  assign ifb.flush_i    = ifa.flush_i;
  assign ifb.ext_mode_i = ifa.ext_mode_i;
  assign ifb.wb_we_i    = ifa.wb_we_i;
  assign ifb.wb_addr_i  = ifa.wb_addr_i;
  assign ifb.wb_data_i  = ifa.wb_data_i;
  assign ifb.ni_we_i    = ifa.ni_we_i;
  assign ifb.ni_addr_i  = ifa.ni_addr_i;
  assign ifb.ni_data_i  = ifa.ni_data_i;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  radd;
    logic [31:0] ext;
  } de_t;

  de_t         qa[$];
  de_t         qb[$];
  de_t         m_a, m_b, exp_v, got;
  logic [31:0] m_rf [32];
  int          n_checks = 0;
  int          n_err = 0;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {6'h00, rs, rt, imm};
  endfunction

  function automatic de_t sample_a();
    return {ifa.valid_o, ifa.rd1_o, ifa.rd2_o, ifa.pc_o, ifa.rs_o, ifa.rt_o, ifa.radd_o, ifa.ext_o};
  endfunction

  function automatic de_t sample_b();
    return {ifb.valid_o, ifb.rd1_o, ifb.rd2_o, ifb.pc_o, ifb.rs_o, ifb.rt_o, ifb.radd_o, ifb.ext_o};
  endfunction

  // Reference model of one read port given the current write-port inputs.
  function automatic logic [31:0] m_read(input logic [4:0] idx, input bit fwd);
    logic [31:0] v;
    v = m_rf[idx];
    if (fwd && ifa.ni_we_i && ifa.ni_addr_i == idx) v = ifa.ni_data_i;
    if (fwd && ifa.wb_we_i && ifa.wb_addr_i == idx) v = ifa.wb_data_i;
    if (idx == 5'd0) v = 32'h0;
    return v;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] ins, input logic [1:0] mode);
    case (mode)
      2'b00:   return {16'h0000, ins[15:0]};
      2'b01:   return {{16{ins[15]}}, ins[15:0]};
      2'b10:   return {ins[15:0], 16'h0000};
      default: return {{6{ins[25]}}, ins[25:0]};
    endcase
  endfunction

  function automatic de_t m_next(input de_t prev, input bit fwd);
    de_t n;
    if (ifa.flush_i) begin
      n = '0;
    end else if (ifa.stall_i) begin
      n = prev;
      if (prev.valid && prev.rs != 5'd0) begin
        if (ifa.ni_we_i && ifa.ni_addr_i == prev.rs) n.rd1 = ifa.ni_data_i;
        if (ifa.wb_we_i && ifa.wb_addr_i == prev.rs) n.rd1 = ifa.wb_data_i;
      end
      if (prev.valid && prev.rt != 5'd0) begin
        if (ifa.ni_we_i && ifa.ni_addr_i == prev.rt) n.rd2 = ifa.ni_data_i;
        if (ifa.wb_we_i && ifa.wb_addr_i == prev.rt) n.rd2 = ifa.wb_data_i;
      end
    end else begin
      n.valid = ifa.valid_i;
      n.rs    = ifa.instr_i[25:21];
      n.rt    = ifa.instr_i[20:16];
      n.radd  = ifa.instr_i[15:11];
      n.rd1   = m_read(ifa.instr_i[25:21], fwd);
      n.rd2   = m_read(ifa.instr_i[20:16], fwd);
      n.pc    = ifa.pc_i;
      n.ext   = m_ext(ifa.instr_i, ifa.ext_mode_i);
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_a = '0;
    m_b = '0;
    qa.delete();
    qb.delete();
  endtask

  // Drive one cycle on the 32-bit instances and queue the expected D/E state.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic valid, input logic stall, input logic flush,
                       input logic [1:0] mode,
                       input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic niwe, input logic [4:0] nia, input logic [31:0] nid);
    ifa.instr_i = instr;  ifa.pc_i = pc;  ifa.valid_i = valid;
    ifa.stall_i = stall;  ifa.flush_i = flush;  ifa.ext_mode_i = mode;
    ifa.wb_we_i = wbwe;   ifa.wb_addr_i = wba;  ifa.wb_data_i = wbd;
    ifa.ni_we_i = niwe;   ifa.ni_addr_i = nia;  ifa.ni_data_i = nid;
    m_a = m_next(m_a, 1'b1);
    m_b = m_next(m_b, 1'b0);
    qa.push_back(m_a);
    qb.push_back(m_b);
    if (niwe && nia != 5'd0) m_rf[nia] = nid;
    if (wbwe && wba != 5'd0) m_rf[wba] = wbd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_c();
    ifc.instr_i = '0; ifc.pc_i = '0; ifc.valid_i = 1'b0; ifc.stall_i = 1'b0;
    ifc.flush_i = 1'b0; ifc.ext_mode_i = '0; ifc.wb_we_i = 1'b0; ifc.wb_addr_i = '0;
    ifc.wb_data_i = '0; ifc.ni_we_i = 1'b0; ifc.ni_addr_i = '0; ifc.ni_data_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) begin
      ifa.instr_i = $urandom; ifa.pc_i = $urandom; ifa.valid_i = 1'($urandom);
      ifa.stall_i = 1'($urandom); ifa.flush_i = 1'($urandom); ifa.ext_mode_i = 2'($urandom);
      ifa.wb_we_i = 1'b1; ifa.wb_addr_i = 5'($urandom); ifa.wb_data_i = $urandom;
      ifa.ni_we_i = 1'b1; ifa.ni_addr_i = 5'($urandom); ifa.ni_data_i = $urandom;
      ifc.instr_i = $urandom; ifc.valid_i = 1'b1; ifc.wb_we_i = 1'b1;
      ifc.wb_addr_i = 4'($urandom); ifc.wb_data_i = {$urandom, $urandom};
      @(posedge clk);
      #1;
      n_checks++;
      if (sample_a() !== '0) begin n_err++; $display("FAIL reset_a got=%h exp=0", sample_a()); end
      n_checks++;
      if (sample_b() !== '0) begin n_err++; $display("FAIL reset_b got=%h exp=0", sample_b()); end
      n_checks++;
      if ({ifc.valid_o, ifc.rd1_o, ifc.rd2_o, ifc.pc_o, ifc.rs_o, ifc.rt_o, ifc.radd_o, ifc.ext_o} !== '0) begin
        n_err++; $display("FAIL reset_c got valid=%b rd1=%h exp all 0", ifc.valid_o, ifc.rd1_o);
      end
    end
    idle_c();
    drive_setup_idle();
    rst = 1'b1;
    model_reset();
    for (int i = 1; i < 32; i++) begin
      drive(mk(5'(i), 5'(i), 16'(i)), 32'(i), 1'b1, 1'b0, 1'b0, 2'b00,
            1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      got = sample_a(); exp_v = qa.pop_front(); n_checks++;
      if (got !== exp_v) begin n_err++; $display("FAIL reset_read_a r%0d got=%h exp=%h", i, got, exp_v); end
      got = sample_b(); exp_v = qb.pop_front(); n_checks++;
      if (got !== exp_v) begin n_err++; $display("FAIL reset_read_b r%0d got=%h exp=%h", i, got, exp_v); end
      n_checks++;
      if (ifa.rd1_o !== 32'h0 || ifa.rd2_o !== 32'h0) begin
        n_err++; $display("FAIL reset_read_zero r%0d got=%h/%h exp=0", i, ifa.rd1_o, ifa.rd2_o);
      end
    end
  endtask

  task automatic drive_setup_idle();
    ifa.instr_i = '0; ifa.pc_i = '0; ifa.valid_i = 1'b0; ifa.stall_i = 1'b0;
    ifa.flush_i = 1'b0; ifa.ext_mode_i = '0; ifa.wb_we_i = 1'b0; ifa.wb_addr_i = '0;
    ifa.wb_data_i = '0; ifa.ni_we_i = 1'b0; ifa.ni_addr_i = '0; ifa.ni_data_i = '0;
  endtask

  task automatic test_write_read();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    got = sample_a(); exp_v = qa.pop_front(); n_checks++;
    if (got !== exp_v) begin n_err++; $display("FAIL wr5_a got=%h exp=%h", got, exp_v); end
    void'(qb.pop_front());
    drive(mk(5'd5, 5'd0, 16'h0), 32'h40, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
    got = sample_a(); exp_v = qa.pop_front(); n_checks++;
    if (got !== exp_v) begin n_err++; $display("FAIL rd5_a got=%h exp=%h", got, exp_v); end
    got = sample_b(); exp_v = qb.pop_front(); n_checks++;
    if (got !== exp_v) begin n_err++; $display("FAIL rd5_b got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (ifa.rd1_o !== 32'hDEADBEEF || ifb.rd1_o !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rd5_value got=%h/%h exp=deadbeef", ifa.rd1_o, ifb.rd1_o);
    end
    drive(mk(5'd0, 5'd5, 16'h0), 32'h44, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    void'(qa.pop_front()); void'(qb.pop_front());
    n_checks++;
    if (ifa.rd1_o !== 32'h0 || ifb.rd1_o !== 32'h0) begin
      n_err++; $display("FAIL r0_read got=%h/%h exp=0", ifa.rd1_o, ifb.rd1_o);
    end
  endtask

  task automatic test_collision();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd7, 32'h33, 1'b0, 5'd0, 32'h0);
    void'(qa.pop_front()); void'(qb.pop_front());
    drive(mk(5'd0, 5'd7, 16'h0), 32'h80, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    got = sample_a(); exp_v = qa.pop_front(); n_checks++;
    if (got !== exp_v) begin n_err++; $display("FAIL coll_a got=%h exp=%h", got, exp_v); end
    got = sample_b(); exp_v = qb.pop_front(); n_checks++;
    if (got !== exp_v) begin n_err++; $display("FAIL coll_b got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (ifa.rd2_o !== 32'h11) begin n_err++; $display("FAIL coll_fwd got=%h exp=11", ifa.rd2_o); end
    n_checks++;
    if (ifb.rd2_o !== 32'h33) begin n_err++; $display("FAIL coll_nofwd got=%h exp=33", ifb.rd2_o); end
    drive(mk(5'd0, 5'd7, 16'h0), 32'h84, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    void'(qa.pop_front()); void'(qb.pop_front());
    n_checks++;
    if (ifa.rd2_o !== 32'h11 || ifb.rd2_o !== 32'h11) begin
      n_err++; $display("FAIL coll_after got=%h/%h exp=11", ifa.rd2_o, ifb.rd2_o);
    end
  endtask

  task automatic test_ext();
    logic [31:0] want [4];
    logic [31:0] ins;
    want[0] = 32'h00008001; want[1] = 32'hFFFF8001; want[2] = 32'h80010000; want[3] = 32'hFE000000;
    for (int m = 0; m < 4; m++) begin
      ins = (m == 3) ? {6'h00, 26'h2000000} : mk(5'd0, 5'd0, 16'h8001);
      drive(ins, 32'h100, 1'b1, 1'b0, 1'b0, 2'(m), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      got = sample_a(); exp_v = qa.pop_front(); void'(qb.pop_front()); n_checks++;
      if (got !== exp_v) begin n_err++; $display("FAIL ext_model m%0d got=%h exp=%h", m, got, exp_v); end
      n_checks++;
      if (ifa.ext_o !== want[m]) begin n_err++; $display("FAIL ext_mode%0d got=%h exp=%h", m, ifa.ext_o, want[m]); end
    end
  endtask

  task automatic test_stall();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd3, 32'h5, 1'b0, 5'd0, 32'h0);
    void'(qa.pop_front()); void'(qb.pop_front());
    drive(mk(5'd3, 5'd0, 16'h4800), 32'h100, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    void'(qa.pop_front()); void'(qb.pop_front());
    n_checks++;
    if (ifa.rd1_o !== 32'h5 || ifa.radd_o !== 5'd9) begin
      n_err++; $display("FAIL stall_capture got rd1=%h radd=%0d exp 5/9", ifa.rd1_o, ifa.radd_o);
    end
    drive(mk(5'd4, 5'd0, 16'h0), 32'h200, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h9);
    got = sample_a(); exp_v = qa.pop_front(); n_checks++;
    if (got !== exp_v) begin n_err++; $display("FAIL stall_a got=%h exp=%h", got, exp_v); end
    got = sample_b(); exp_v = qb.pop_front(); n_checks++;
    if (got !== exp_v) begin n_err++; $display("FAIL stall_b got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (ifa.rd1_o !== 32'h9 || ifb.rd1_o !== 32'h9 || ifa.pc_o !== 32'h100 ||
        ifa.radd_o !== 5'd9 || ifa.valid_o !== 1'b1) begin
      n_err++; $display("FAIL stall_refresh got rd1=%h/%h pc=%h radd=%0d v=%b exp 9/9 100 9 1",
                        ifa.rd1_o, ifb.rd1_o, ifa.pc_o, ifa.radd_o, ifa.valid_o);
    end
    drive(mk(5'd4, 5'd0, 16'h0), 32'h200, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    void'(qa.pop_front()); void'(qb.pop_front());
    n_checks++;
    if (ifa.valid_o !== 1'b0 || ifb.valid_o !== 1'b0 || ifa.pc_o !== 32'h0) begin
      n_err++; $display("FAIL flush_stall got v=%b/%b pc=%h exp 0/0 0", ifa.valid_o, ifb.valid_o, ifa.pc_o);
    end
  endtask

  task automatic test_param();
    ifc.wb_we_i = 1'b1; ifc.wb_addr_i = 4'd3; ifc.wb_data_i = 64'hA5A5_0000_1234_5678;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    void'(qa.pop_front()); void'(qb.pop_front());
    ifc.wb_we_i = 1'b0; ifc.instr_i = mk(5'h13, 5'h1F, 16'hFFFF); ifc.ext_mode_i = 2'b01;
    ifc.valid_i = 1'b1; ifc.pc_i = 64'h1_0000_0000;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    void'(qa.pop_front()); void'(qb.pop_front());
    n_checks++;
    if (ifc.rd1_o !== 64'hA5A5_0000_1234_5678 || ifc.rs_o !== 4'h3) begin
      n_err++; $display("FAIL param_rs got rd1=%h rs=%h exp a5a5000012345678 3", ifc.rd1_o, ifc.rs_o);
    end
    n_checks++;
    if (ifc.ext_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL param_sext got=%h exp=ffffffffffffffff", ifc.ext_o);
    end
    n_checks++;
    if (ifc.rd2_o !== 64'h0 || ifc.rt_o !== 4'hF || ifc.radd_o !== 4'hF ||
        ifc.valid_o !== 1'b1 || ifc.pc_o !== 64'h1_0000_0000) begin
      n_err++; $display("FAIL param_fields got rd2=%h rt=%h radd=%h v=%b pc=%h exp 0 f f 1 100000000",
                        ifc.rd2_o, ifc.rt_o, ifc.radd_o, ifc.valid_o, ifc.pc_o);
    end
    idle_c();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 120; k++) begin
      drive(mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)), $urandom,
            1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0), 2'($urandom),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      got = sample_a(); exp_v = qa.pop_front(); n_checks++;
      if (got !== exp_v) begin n_err++; $display("FAIL b2b_a cyc%0d got=%h exp=%h", k, got, exp_v); end
      got = sample_b(); exp_v = qb.pop_front(); n_checks++;
      if (got !== exp_v) begin n_err++; $display("FAIL b2b_b cyc%0d got=%h exp=%h", k, got, exp_v); end
    end
  endtask

  task automatic test_mid_reset();
    drive(mk(5'd10, 5'd0, 16'h0), 32'h300, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd10, 32'hCAFE, 1'b0, 5'd0, 32'h0);
    void'(qa.pop_front()); void'(qb.pop_front());
    n_checks++;
    if (ifa.rd1_o !== 32'hCAFE) begin n_err++; $display("FAIL midrst_pre got=%h exp=cafe", ifa.rd1_o); end
    rst = 1'b0;
    #2;
    n_checks++;
    if (sample_a() !== '0 || sample_b() !== '0) begin
      n_err++; $display("FAIL midrst_async got=%h/%h exp=0", sample_a(), sample_b());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    drive(mk(5'd10, 5'd0, 16'h0), 32'h304, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    got = sample_a(); exp_v = qa.pop_front(); void'(qb.pop_front()); n_checks++;
    if (got !== exp_v) begin n_err++; $display("FAIL midrst_model got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (ifa.rd1_o !== 32'h0) begin n_err++; $display("FAIL midrst_cleared got=%h exp=0", ifa.rd1_o); end
  endtask

  initial begin
    rst = 1'b0;
    drive_setup_idle();
    idle_c();
    model_reset();
    #1;
    test_reset();
    test_write_read();
    test_collision();
    test_ext();
    test_stall();
    test_param();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
